score_counter: RTL

Sequential score engine for the dyno game, directly upstream of the digit/ROM-address stage. Counts gameplay frames into points while a run is active and freezes on collision. Holds the all-time high score until reset and derives a speed level for the obstacle generator. Drives the 17-bit binary `score` consumed by the score-digit addressing stage.

---
 rtl/score_pkg.sv | 30 +++
 rtl/tick_prescaler.sv | 40 ++++
 rtl/score_counter.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/score_pkg.sv
// Shared types and constants for the dyno-game score engine.
// Imported by score_counter and tick_prescaler.
package score_pkg;

  localparam int SCORE_W = 17;
  localparam int SPEED_W = 4;
  localparam int PRESC_W = 6;
  localparam int HUND_W  = 7;

  localparam int unsigned SCORE_MAX_DEF = 99999;

  localparam logic [SPEED_W-1:0] SPEED_MAX = 4'd15;
  localparam logic [HUND_W-1:0]  HUND_LAST = 7'd99;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    OVER = 2'd2
  } score_state_t;

  // Speed level increments but never wraps past its maximum.
  function automatic logic [SPEED_W-1:0] speed_sat_inc(input logic [SPEED_W-1:0] v);
    if (v == SPEED_MAX) begin
      return v;
    end else begin
      return v + 4'd1;
    end
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Divides frame ticks by TICKS_PER_POINT and flags the tick that completes a point.
// The counter only advances while enabled and restarts on a synchronous clear.
module tick_prescaler
  import score_pkg::*;
#(
  parameter int unsigned TICKS_PER_POINT = 6
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  input  logic frame_tick,
  output logic point_tick
);

  localparam logic [PRESC_W-1:0] LAST_TICK = PRESC_W'(TICKS_PER_POINT - 1);

  logic [PRESC_W-1:0] cnt_r;
  logic               at_last_s;

  assign at_last_s = (cnt_r == LAST_TICK);

  // point_tick is left combinational so the score register can update on the
  // very edge that samples the completing frame tick.
  assign point_tick = en & frame_tick & at_last_s;

  // Modulo-TICKS_PER_POINT frame counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_r <= 6'd0;
    end else if (clr) begin
      cnt_r <= 6'd0;
    end else if (en && frame_tick) begin
      cnt_r <= at_last_s ? 6'd0 : cnt_r + 6'd1;
    end else begin
      cnt_r <= cnt_r;
    end
  end

endmodule

// File: rtl/score_counter.sv
// Score engine: IDLE/RUN/OVER FSM, saturating score, hundreds-based speed level
// and an all-time high score, all outputs registered.
module score_counter
  import score_pkg::*;
#(
  parameter int unsigned TICKS_PER_POINT = 6,
  parameter int unsigned SCORE_MAX       = SCORE_MAX_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               frame_tick,
  input  logic               start,
  input  logic               collision,
  output logic [SCORE_W-1:0] score,
  output logic [SCORE_W-1:0] hi_score,
  output logic [SPEED_W-1:0] speed_level,
  output logic               running,
  output logic               game_over,
  output logic               new_hi
);

  localparam logic [SCORE_W-1:0] SCORE_CAP = SCORE_W'(SCORE_MAX);

  score_state_t       state_r;
  score_state_t       state_nx_s;
  logic [SCORE_W-1:0] score_r;
  logic [SCORE_W-1:0] hi_r;
  logic [SPEED_W-1:0] speed_r;
  logic [HUND_W-1:0]  hund_r;
  logic               running_r;
  logic               over_r;
  logic               new_hi_r;

  logic               point_tick_s;
  logic               start_run_s;
  logic               collide_s;
  logic               bump_s;
  logic               hund_wrap_s;

  tick_prescaler #(
    .TICKS_PER_POINT (TICKS_PER_POINT)
  ) u_prescaler (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (start_run_s),
    .en         (state_r == RUN),
    .frame_tick (frame_tick),
    .point_tick (point_tick_s)
  );

  // Next-state decode plus the qualified start/collision strobes.
  always_comb begin
    state_nx_s  = state_r;
    start_run_s = 1'b0;
    collide_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_nx_s  = RUN;
          start_run_s = 1'b1;
        end else begin
          state_nx_s = IDLE;
        end
      end
      RUN: begin
        if (collision) begin
          state_nx_s = OVER;
          collide_s  = 1'b1;
        end else begin
          state_nx_s = RUN;
        end
      end
      OVER: begin
        if (start) begin
          state_nx_s  = RUN;
          start_run_s = 1'b1;
        end else begin
          state_nx_s = OVER;
        end
      end
      default: begin
        state_nx_s = IDLE;
      end
    endcase
  end

  // A point only counts when it is not pre-empted by a collision or the cap.
  always_comb begin
    bump_s      = 1'b0;
    hund_wrap_s = 1'b0;
    if ((state_r == RUN) && !collision && point_tick_s && (score_r != SCORE_CAP)) begin
      bump_s      = 1'b1;
      hund_wrap_s = (hund_r == HUND_LAST);
    end else begin
      bump_s      = 1'b0;
      hund_wrap_s = 1'b0;
    end
  end

  // State, score, speed, high-score and status registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      score_r   <= 17'd0;
      hi_r      <= 17'd0;
      speed_r   <= 4'd0;
      hund_r    <= 7'd0;
      running_r <= 1'b0;
      over_r    <= 1'b0;
      new_hi_r  <= 1'b0;
    end else begin
      state_r   <= state_nx_s;
      running_r <= (state_nx_s == RUN);
      over_r    <= (state_nx_s == OVER);
      if (start_run_s) begin
        score_r  <= 17'd0;
        hund_r   <= 7'd0;
        speed_r  <= 4'd0;
        new_hi_r <= 1'b0;
      end else if (collide_s) begin
        if (score_r > hi_r) begin
          hi_r     <= score_r;
          new_hi_r <= 1'b1;
        end
      end else if (bump_s) begin
        score_r <= score_r + 17'd1;
        if (hund_wrap_s) begin
          hund_r  <= 7'd0;
          speed_r <= speed_sat_inc(speed_r);
        end else begin
          hund_r <= hund_r + 7'd1;
        end
      end
    end
  end

  assign score       = score_r;
  assign hi_score    = hi_r;
  assign speed_level = speed_r;
  assign running     = running_r;
  assign game_over   = over_r;
  assign new_hi      = new_hi_r;

endmodule
